// File: rtl/sd_pic_unpack_if.sv
// Byte-stream input and image-buffer write port of the SD picture unpacker.
// The master side feeds card bytes; the slave side (the unpacker) drives the writes.
interface sd_pic_unpack_if;
  logic       init;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       read_done;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  modport master (
    output init, byte_valid, byte_data, read_done,
    input  wr_en, wr_addr, wr_data, frame_done, frame_err, busy
  );

  modport slave (
    input  init, byte_valid, byte_data, read_done,
    output wr_en, wr_addr, wr_data, frame_done, frame_err, busy
  );
endinterface

// File: rtl/sd_pic_unpack.sv
// Turns a raw 8-bit BMP byte stream from the SD card into raster-ordered
// pixel writes for the 28x28 image buffer, with optional invert/binarize.
module sd_pic_unpack #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int HDR_BYTES = 1078,
  parameter int BOTTOM_UP = 1,
  parameter int INVERT    = 1,
  parameter int BINARIZE  = 0,
  parameter int THRESH    = 128
) (
  input  logic             SD_clk,
  input  logic             rst_n,
  sd_pic_unpack_if.slave   bus
);

  localparam int STRIDE = ((IMG_W + 3) / 4) * 4;
  localparam int PAD    = STRIDE - IMG_W;

  localparam logic [10:0] HDR_LAST   = 11'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);
  localparam logic [10:0] PAD_LAST   = 11'((PAD > 0) ? PAD - 1 : 0);
  localparam logic [4:0]  COL_LAST   = 5'(IMG_W - 1);
  localparam logic [4:0]  ROW_LAST   = 5'(IMG_H - 1);
  localparam logic [9:0]  ROW_LAST_A = 10'(IMG_H - 1);
  localparam logic [9:0]  IMG_W_A    = 10'(IMG_W);
  localparam logic [7:0]  THRESH_B   = 8'(THRESH);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PIX, S_PAD, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [10:0] r_cnt, w_cnt;
  logic [4:0]  r_row, w_row;
  logic [4:0]  r_col, w_col;
  logic        r_rd_d;
  logic        r_wr_en;
  logic [9:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_frame_done;
  logic        r_frame_err;

  logic        w_acc, w_rd_rise, w_last;
  logic        w_wr, w_fd, w_err_set, w_err_clr;
  logic [9:0]  w_row_eff, w_addr;
  logic [7:0]  w_pix;

  // Invert first, then threshold the inverted value.
  function automatic logic [7:0] f_proc(input logic [7:0] b);
    logic [7:0] v;
    v = (INVERT != 0) ? ~b : b;
    if (BINARIZE != 0) v = (v >= THRESH_B) ? 8'hFF : 8'h00;
    return v;
  endfunction

  assign w_acc     = bus.byte_valid & bus.init;
  assign w_rd_rise = bus.read_done & ~r_rd_d;
  assign w_last    = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_row_eff = (BOTTOM_UP != 0) ? (ROW_LAST_A - {5'd0, r_row}) : {5'd0, r_row};
  assign w_addr    = w_row_eff * IMG_W_A + {5'd0, r_col};
  assign w_pix     = f_proc(bus.byte_data);

  always_comb begin
    w_next    = r_state;
    w_cnt     = r_cnt;
    w_row     = r_row;
    w_col     = r_col;
    w_wr      = 1'b0;
    w_fd      = 1'b0;
    w_err_set = 1'b0;
    w_err_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.init) begin
          w_cnt     = '0;
          w_row     = '0;
          w_col     = '0;
          w_err_clr = 1'b1;
          w_next    = (HDR_BYTES == 0) ? S_PIX : S_HDR;
        end
      end
      S_HDR: begin
        if (!bus.init) begin
          w_next = S_IDLE;
        end else if (w_rd_rise) begin
          w_err_set = 1'b1;
          w_next    = S_IDLE;
        end else if (w_acc) begin
          if (r_cnt == HDR_LAST) begin
            w_cnt  = '0;
            w_next = S_PIX;
          end else begin
            w_cnt = r_cnt + 11'd1;
          end
        end
      end
      S_PIX: begin
        // A last pixel arriving together with read_done still completes the frame.
        if (!bus.init) begin
          w_next = S_IDLE;
        end else if (w_rd_rise && !(w_acc && w_last)) begin
          w_err_set = 1'b1;
          w_next    = S_IDLE;
        end else if (w_acc) begin
          w_wr = 1'b1;
          if (w_last) begin
            w_fd   = 1'b1;
            w_next = S_DONE;
          end else if (r_col == COL_LAST) begin
            w_col = '0;
            if (PAD > 0) begin
              w_cnt  = '0;
              w_next = S_PAD;
            end else begin
              w_row = r_row + 5'd1;
            end
          end else begin
            w_col = r_col + 5'd1;
          end
        end
      end
      S_PAD: begin
        if (!bus.init) begin
          w_next = S_IDLE;
        end else if (w_rd_rise) begin
          w_err_set = 1'b1;
          w_next    = S_IDLE;
        end else if (w_acc) begin
          if (r_cnt == PAD_LAST) begin
            w_cnt  = '0;
            w_row  = r_row + 5'd1;
            w_next = S_PIX;
          end else begin
            w_cnt = r_cnt + 11'd1;
          end
        end
      end
      S_DONE: begin
        if (!bus.init || w_rd_rise) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_rd_d       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt;
      r_row        <= w_row;
      r_col        <= w_col;
      r_rd_d       <= bus.read_done;
      r_wr_en      <= w_wr;
      r_frame_done <= w_fd;
      if (w_wr) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_pix;
      end
      if (w_err_clr)      r_frame_err <= 1'b0;
      else if (w_err_set) r_frame_err <= 1'b1;
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = (r_state == S_HDR) || (r_state == S_PIX) || (r_state == S_PAD);

endmodule

// File: tb/tb_sd_pic_unpack.sv
// Drives one shared byte stream into four differently configured unpackers and
// checks each against a byte-index based model of the BMP layout.
module tb_sd_pic_unpack;
  localparam int HDR = 1078;
  localparam int H   = 28;
  localparam int NI  = 4;

  logic       SD_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic       read_done = 1'b0;

  always #5 SD_clk = ~SD_clk;

  sd_pic_unpack_if if0 ();
  sd_pic_unpack_if if1 ();
  sd_pic_unpack_if if2 ();
  sd_pic_unpack_if if3 ();

  assign if0.init = init; assign if0.byte_valid = byte_valid; assign if0.byte_data = byte_data; assign if0.read_done = read_done;
  assign if1.init = init; assign if1.byte_valid = byte_valid; assign if1.byte_data = byte_data; assign if1.read_done = read_done;
  assign if2.init = init; assign if2.byte_valid = byte_valid; assign if2.byte_data = byte_data; assign if2.read_done = read_done;
  assign if3.init = init; assign if3.byte_valid = byte_valid; assign if3.byte_data = byte_data; assign if3.read_done = read_done;

  // A: defaults; B: 27 wide top-down; C: binarize top-down; D: plain top-down
  sd_pic_unpack #(.IMG_W(28), .IMG_H(28), .HDR_BYTES(HDR), .BOTTOM_UP(1), .INVERT(1), .BINARIZE(0), .THRESH(128))
    u_a (.SD_clk(SD_clk), .rst_n(rst_n), .bus(if0.slave));
  sd_pic_unpack #(.IMG_W(27), .IMG_H(28), .HDR_BYTES(HDR), .BOTTOM_UP(0), .INVERT(0), .BINARIZE(0), .THRESH(128))
    u_b (.SD_clk(SD_clk), .rst_n(rst_n), .bus(if1.slave));
  sd_pic_unpack #(.IMG_W(28), .IMG_H(28), .HDR_BYTES(HDR), .BOTTOM_UP(0), .INVERT(0), .BINARIZE(1), .THRESH(128))
    u_c (.SD_clk(SD_clk), .rst_n(rst_n), .bus(if2.slave));
  sd_pic_unpack #(.IMG_W(28), .IMG_H(28), .HDR_BYTES(HDR), .BOTTOM_UP(0), .INVERT(0), .BINARIZE(0), .THRESH(128))
    u_d (.SD_clk(SD_clk), .rst_n(rst_n), .bus(if3.slave));

  logic       d_wr [NI];
  logic [9:0] d_addr [NI];
  logic [7:0] d_data [NI];
  logic       d_fd [NI];
  logic       d_err [NI];
  logic       d_busy [NI];

  assign d_wr[0] = if0.wr_en; assign d_addr[0] = if0.wr_addr; assign d_data[0] = if0.wr_data;
  assign d_fd[0] = if0.frame_done; assign d_err[0] = if0.frame_err; assign d_busy[0] = if0.busy;
  assign d_wr[1] = if1.wr_en; assign d_addr[1] = if1.wr_addr; assign d_data[1] = if1.wr_data;
  assign d_fd[1] = if1.frame_done; assign d_err[1] = if1.frame_err; assign d_busy[1] = if1.busy;
  assign d_wr[2] = if2.wr_en; assign d_addr[2] = if2.wr_addr; assign d_data[2] = if2.wr_data;
  assign d_fd[2] = if2.frame_done; assign d_err[2] = if2.frame_err; assign d_busy[2] = if2.busy;
  assign d_wr[3] = if3.wr_en; assign d_addr[3] = if3.wr_addr; assign d_data[3] = if3.wr_data;
  assign d_fd[3] = if3.frame_done; assign d_err[3] = if3.frame_err; assign d_busy[3] = if3.busy;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  function automatic int  cfg_w(input int i);   return (i == 1) ? 27 : 28; endfunction
  function automatic bit  cfg_bu(input int i);  return i == 0; endfunction
  function automatic bit  cfg_inv(input int i); return i == 0; endfunction
  function automatic bit  cfg_bin(input int i); return i == 2; endfunction

  function automatic logic [7:0] ref_pix(input int i, input logic [7:0] b);
    int v;
    v = cfg_inv(i) ? 255 - int'(b) : int'(b);
    if (cfg_bin(i)) v = (v >= 128) ? 255 : 0;
    return 8'(v);
  endfunction

  // Model: phase 0 = idle, 1 = consuming the frame, 2 = frame complete.
  int         m_phase [NI];
  int         m_k [NI];
  logic       m_err [NI];
  logic       rd_prev;
  logic       e_wr [NI];
  logic [9:0] e_addr [NI];
  logic [7:0] e_data [NI];
  logic       e_fd [NI];
  logic       e_err [NI];
  logic       e_busy [NI];

  task automatic model_reset();
    rd_prev = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_phase[i] = 0; m_k[i] = 0; m_err[i] = 1'b0;
      e_wr[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
      e_fd[i] = 1'b0; e_err[i] = 1'b0; e_busy[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit rd_rise, is_pix, last;
    int p, r, c, w;
    rd_rise = read_done && !rd_prev;
    for (int i = 0; i < NI; i++) begin
      e_wr[i] = 1'b0;
      e_fd[i] = 1'b0;
      w = cfg_w(i);
      if (!init) begin
        m_phase[i] = 0;
      end else if (m_phase[i] == 0) begin
        m_phase[i] = 1; m_k[i] = 0; m_err[i] = 1'b0;
      end else if (m_phase[i] == 1) begin
        is_pix = 0; last = 0; r = 0; c = 0;
        if (byte_valid && m_k[i] >= HDR) begin
          p = m_k[i] - HDR;
          r = p / 28;
          c = p % 28;
          if (c < w) begin
            is_pix = 1;
            last = (r == H - 1) && (c == w - 1);
          end
        end
        if (rd_rise && !last) begin
          m_err[i] = 1'b1; m_phase[i] = 0;
        end else if (byte_valid) begin
          m_k[i]++;
          if (is_pix) begin
            e_wr[i]   = 1'b1;
            e_addr[i] = 10'((cfg_bu(i) ? (H - 1 - r) : r) * w + c);
            e_data[i] = ref_pix(i, byte_data);
            if (last) begin
              e_fd[i] = 1'b1; m_phase[i] = 2;
            end
          end
        end
      end else if (rd_rise) begin
        m_phase[i] = 0;
      end
      e_err[i]  = m_err[i];
      e_busy[i] = (m_phase[i] == 1);
    end
    rd_prev = read_done;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge SD_clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  logic [7:0] mem [NI][1024];
  int nwr [NI];
  int nfd [NI];

  initial begin
    forever begin
      @(negedge SD_clk);
      for (int i = 0; i < NI; i++) begin
        chk("wr_en", i, 32'(d_wr[i]), 32'(e_wr[i]));
        if (e_wr[i]) begin
          chk("wr_addr", i, 32'(d_addr[i]), 32'(e_addr[i]));
          chk("wr_data", i, 32'(d_data[i]), 32'(e_data[i]));
        end
        chk("frame_done", i, 32'(d_fd[i]), 32'(e_fd[i]));
        chk("frame_err", i, 32'(d_err[i]), 32'(e_err[i]));
        chk("busy", i, 32'(d_busy[i]), 32'(e_busy[i]));
        if (d_wr[i] === 1'b1) begin
          mem[i][d_addr[i]] = d_data[i];
          nwr[i]++;
        end
        if (d_fd[i] === 1'b1) nfd[i]++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    $fatal(1, "simulation timeout");
  end

  task automatic clear_stats();
    for (int i = 0; i < NI; i++) begin
      nwr[i] = 0; nfd[i] = 0;
      for (int a = 0; a < 1024; a++) mem[i][a] = 8'h5A;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge SD_clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge SD_clk);
  endtask

  function automatic int gap_of(input int mode);
    if (mode == 0) return 1;
    if (mode == 1) return 0;
    return int'($urandom_range(0, 2));
  endfunction

  // mode 0: pixel value = index, one valid every 2 cycles; 1: continuous random; 2: random gaps
  task automatic run_frame(input int mode, input int npix);
    int total;
    total = (npix < 0) ? 784 : npix;
    init = 1'b1;
    repeat (2) @(negedge SD_clk);
    for (int k = 0; k < HDR; k++) send(8'($urandom), gap_of(mode));
    for (int p = 0; p < total; p++) send((mode == 0) ? 8'(p) : 8'($urandom), gap_of(mode));
    repeat (3) @(negedge SD_clk);
  endtask

  task automatic end_frame();
    read_done = 1'b1;
    @(negedge SD_clk);
    init = 1'b0;
    read_done = 1'b0;
    repeat (2) @(negedge SD_clk);
  endtask

  task automatic check_complete();
    for (int i = 0; i < NI; i++) begin
      chk("write_count", i, 32'(nwr[i]), 32'(cfg_w(i) * H));
      chk("done_count", i, 32'(nfd[i]), 32'd1);
      chk("err_clear", i, 32'(d_err[i]), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge SD_clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_wr_en", i, 32'(d_wr[i]), 32'd0);
      chk("rst_busy", i, 32'(d_busy[i]), 32'd0);
      chk("rst_err", i, 32'(d_err[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge SD_clk);

    clear_stats();
    run_frame(0, -1);
    check_complete();
    chk("first_pixel", 0, 32'(mem[0][756]), 32'd255);
    chk("last_pixel", 0, 32'(mem[0][27]), 32'd240);
    chk("pad_row1", 1, 32'(mem[1][27]), 32'd28);
    chk("pad_last", 1, 32'(mem[1][728]), 32'd242);
    chk("bin_127", 2, 32'(mem[2][127]), 32'h00);
    chk("bin_128", 2, 32'(mem[2][128]), 32'hFF);
    chk("bin_255", 2, 32'(mem[2][255]), 32'hFF);
    chk("plain_783", 3, 32'(mem[3][783]), 32'd15);
    end_frame();

    clear_stats();
    run_frame(1, -1);
    check_complete();
    end_frame();

    clear_stats();
    run_frame(2, 500);
    read_done = 1'b1;
    @(negedge SD_clk);
    init = 1'b0;
    read_done = 1'b0;
    repeat (2) @(negedge SD_clk);
    for (int i = 0; i < NI; i++) begin
      chk("abort_err", i, 32'(d_err[i]), 32'd1);
      chk("abort_done", i, 32'(nfd[i]), 32'd0);
      chk("abort_writes", i, 32'(nwr[i]), (i == 1) ? 32'd483 : 32'd500);
    end

    clear_stats();
    run_frame(2, -1);
    check_complete();
    end_frame();

    clear_stats();
    init = 1'b1;
    repeat (2) @(negedge SD_clk);
    for (int k = 0; k < HDR + 300; k++) send(8'($urandom), 0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("async_wr_en", i, 32'(d_wr[i]), 32'd0);
      chk("async_addr", i, 32'(d_addr[i]), 32'd0);
      chk("async_data", i, 32'(d_data[i]), 32'd0);
      chk("async_busy", i, 32'(d_busy[i]), 32'd0);
    end
    repeat (2) @(negedge SD_clk);
    rst_n = 1'b1;
    clear_stats();
    run_frame(0, -1);
    check_complete();
    chk("restart_first", 0, 32'(mem[0][756]), 32'd255);
    chk("restart_last", 0, 32'(mem[0][27]), 32'd240);
    end_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
